hs_ram_arbiter: RTL and testbench

Shares the game core's work-RAM port between the Z80 side of the core and the hiscore save/restore engine. When the hiscore engine requests a session, the arbiter:
- raises a pause request to the core and waits for the core to acknowledge a safe halt;
- hands the RAM port to the hiscore engine for single-byte transfers;
- returns the port to the CPU before releasing pause.

It sits between the hiscore module, the pause logic and the core's shared RAM, all on `clk_sys`.

---
 rtl/hs_ram_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_hs_ram_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_ram_arbiter.sv
// Work-RAM port arbiter between the core CPU and the hiscore save/restore engine.
// Pauses the core, hands the port over for single-byte transfers, then gives it back.
module hs_ram_arbiter #(
    parameter int AW      = 11,
    parameter int DW      = 8,
    parameter int RD_LAT  = 1,
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          hs_req,
    input  logic          hs_stb,
    input  logic          hs_we,
    input  logic [AW-1:0] hs_addr,
    input  logic [DW-1:0] hs_wdata,
    output logic          hs_grant,
    output logic          hs_ack,
    output logic [DW-1:0] hs_rdata,
    output logic          timeout,
    output logic          pause_req,
    input  logic          pause_ack,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_we,
    output logic [DW-1:0] cpu_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SETTLE,
        S_OWN,
        S_XFER,
        S_REL,
        S_ABORT
    } state_t;

    localparam logic [9:0] TO_C     = 10'(TIMEOUT);
    localparam logic [3:0] SETTLE_C = 4'(SETTLE);
    localparam logic [1:0] RD_LAT_C = 2'(RD_LAT);

    state_t        state_q, state_d;
    logic [9:0]    wait_q, wait_d;
    logic [3:0]    settle_q, settle_d;
    logic [1:0]    lat_q, lat_d;
    logic [AW-1:0] xaddr_q, xaddr_d;
    logic [DW-1:0] xdata_q, xdata_d;
    logic          xwe_q, xwe_d;
    logic          ack_q, ack_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic [9:0] wait_inc;
    logic [3:0] settle_inc;

    assign wait_inc   = wait_q + 10'd1;
    assign settle_inc = settle_q + 4'd1;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            wait_q   <= '0;
            settle_q <= '0;
            lat_q    <= '0;
            xaddr_q  <= '0;
            xdata_q  <= '0;
            xwe_q    <= 1'b0;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            settle_q <= settle_d;
            lat_q    <= lat_d;
            xaddr_q  <= xaddr_d;
            xdata_q  <= xdata_d;
            xwe_q    <= xwe_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        settle_d = settle_q;
        lat_d    = lat_q;
        xaddr_d  = xaddr_q;
        xdata_d  = xdata_q;
        xwe_d    = xwe_q;
        ack_d    = 1'b0;
        rdata_d  = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (hs_req) begin
                    state_d = S_WAIT;
                    wait_d  = '0;
                end
            end
            S_WAIT: begin
                wait_d = wait_inc;
                if (!hs_req) begin
                    state_d = S_REL;
                end else if (pause_ack) begin
                    state_d  = S_SETTLE;
                    settle_d = '0;
                end else if (wait_inc == TO_C) begin
                    state_d = S_ABORT;
                end
            end
            S_SETTLE: begin
                if (!hs_req) begin
                    state_d = S_REL;
                end else if (!pause_ack) begin
                    state_d = S_WAIT;
                end else if (settle_inc == SETTLE_C) begin
                    state_d = S_OWN;
                end else begin
                    settle_d = settle_inc;
                end
            end
            S_OWN: begin
                if (hs_stb) begin
                    state_d = S_XFER;
                    xaddr_d = hs_addr;
                    xdata_d = hs_wdata;
                    xwe_d   = hs_we;
                    lat_d   = '0;
                end else if (!hs_req) begin
                    state_d = S_REL;
                end
            end
            S_XFER: begin
                lat_d = lat_q + 2'd1;
                // Reads hold the address one extra cycle so RAM data lands before capture
                if (xwe_q) begin
                    state_d = S_OWN;
                    ack_d   = 1'b1;
                end else if (lat_q == RD_LAT_C) begin
                    state_d = S_OWN;
                    ack_d   = 1'b1;
                    rdata_d = ram_rdata;
                end
            end
            S_REL: begin
                state_d = S_IDLE;
            end
            S_ABORT: begin
                if (!hs_req) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign hs_grant  = (state_q == S_OWN) || (state_q == S_XFER);
    assign hs_ack    = ack_q;
    assign hs_rdata  = rdata_q;
    assign timeout   = (state_q == S_ABORT);
    assign pause_req = (state_q == S_WAIT) || (state_q == S_SETTLE) ||
                       (state_q == S_OWN)  || (state_q == S_XFER)   ||
                       (state_q == S_REL);

    assign cpu_rdata = ram_rdata;

    always_comb begin
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_we    = cpu_we;
        if (state_q == S_XFER) begin
            ram_addr  = xaddr_q;
            ram_wdata = xdata_q;
            ram_we    = xwe_q && (lat_q == 2'd0);
        end else if ((state_q == S_OWN) || (state_q == S_REL)) begin
            ram_we = 1'b0;
        end
    end

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Directed bench for hs_ram_arbiter: session, transfers, settle glitch,
// timeout, release during read and reset mid-transfer.
module tb_hs_ram_arbiter;

    localparam int AW = 11;
    localparam int DW = 8;

    logic          clk_sys = 1'b0;
    logic          reset_n;
    logic          hs_req, hs_stb, hs_we;
    logic [AW-1:0] hs_addr;
    logic [DW-1:0] hs_wdata;
    logic          hs_grant, hs_ack, timeout, pause_req, pause_ack;
    logic [DW-1:0] hs_rdata;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_we;
    logic [DW-1:0] cpu_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we;
    logic [DW-1:0] ram_rdata;

    logic          ack_auto, ack_man;
    logic [2:0]    dly;
    logic [DW-1:0] mem [0:2047];

    int checks = 0;
    int errors = 0;

    always #5 clk_sys = ~clk_sys;

    hs_ram_arbiter dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .hs_req   (hs_req),
        .hs_stb   (hs_stb),
        .hs_we    (hs_we),
        .hs_addr  (hs_addr),
        .hs_wdata (hs_wdata),
        .hs_grant (hs_grant),
        .hs_ack   (hs_ack),
        .hs_rdata (hs_rdata),
        .timeout  (timeout),
        .pause_req(pause_req),
        .pause_ack(pause_ack),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_we   (cpu_we),
        .cpu_rdata(cpu_rdata),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_we   (ram_we),
        .ram_rdata(ram_rdata)
    );

    // Core model: pause_ack follows pause_req three cycles late
    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) dly <= '0;
        else          dly <= {dly[1:0], pause_req};
    end
    assign pause_ack = ack_auto ? dly[2] : ack_man;

    // Single-port RAM, one cycle read latency
    always @(posedge clk_sys) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        hs_req    = 1'b0;
        hs_stb    = 1'b0;
        hs_we     = 1'b0;
        hs_addr   = '0;
        hs_wdata  = '0;
        ack_auto  = 1'b0;
        ack_man   = 1'b0;
        cpu_addr  = 11'h010;
        cpu_wdata = 8'hC3;
        cpu_we    = 1'b1;
        #1;
        chk("rst_grant", 32'(hs_grant), 0);
        chk("rst_pause", 32'(pause_req), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_ack", 32'(hs_ack), 0);
        chk("rst_rdata", 32'(hs_rdata), 0);
        chk("rst_ram_addr", 32'(ram_addr), 32'h010);
        chk("rst_ram_wdata", 32'(ram_wdata), 32'hC3);
        chk("rst_ram_we", 32'(ram_we), 1);
        tick();
        tick();
        cpu_we = 1'b0;
        chk("cpu_rdata", 32'(cpu_rdata), 32'(ram_rdata));
        reset_n = 1'b1;
        tick();

        // Basic session with delayed pause_ack
        ack_auto = 1'b1;
        hs_req   = 1'b1;
        tick();
        chk("pause_rise", 32'(pause_req), 1);
        chk("grant_early", 32'(hs_grant), 0);
        repeat (3) tick();
        chk("ack_seen", 32'(pause_ack), 1);
        repeat (4) tick();
        chk("grant_settle4", 32'(hs_grant), 0);
        tick();
        chk("grant_rise", 32'(hs_grant), 1);

        // Write 0x5C to 0x3A5; CPU write must be blocked in OWN
        cpu_addr = 11'h111;
        cpu_we   = 1'b1;
        hs_stb   = 1'b1;
        hs_we    = 1'b1;
        hs_addr  = 11'h3A5;
        hs_wdata = 8'h5C;
        #1;
        chk("own_we_block", 32'(ram_we), 0);
        tick();
        hs_stb   = 1'b0;
        hs_addr  = '0;
        hs_wdata = '0;
        chk("wr_we", 32'(ram_we), 1);
        chk("wr_addr", 32'(ram_addr), 32'h3A5);
        chk("wr_data", 32'(ram_wdata), 32'h5C);
        chk("wr_ack_early", 32'(hs_ack), 0);
        tick();
        chk("wr_ack", 32'(hs_ack), 1);
        chk("wr_we_done", 32'(ram_we), 0);
        tick();
        chk("wr_ack_pulse", 32'(hs_ack), 0);

        // Read back 0x3A5
        hs_stb  = 1'b1;
        hs_we   = 1'b0;
        hs_addr = 11'h3A5;
        tick();
        hs_stb  = 1'b0;
        hs_addr = '0;
        chk("rd_addr", 32'(ram_addr), 32'h3A5);
        chk("rd_we", 32'(ram_we), 0);
        tick();
        chk("rd_ack_early", 32'(hs_ack), 0);
        chk("rd_addr_hold", 32'(ram_addr), 32'h3A5);
        tick();
        chk("rd_ack", 32'(hs_ack), 1);
        chk("rd_data", 32'(hs_rdata), 32'h5C);

        // Back-to-back read of 0x010, hs_req drops mid-transfer
        hs_stb  = 1'b1;
        hs_addr = 11'h010;
        tick();
        hs_stb = 1'b0;
        hs_req = 1'b0;
        chk("rel_xfer_grant", 32'(hs_grant), 1);
        chk("rel_xfer_we", 32'(ram_we), 0);
        tick();
        chk("rel_xfer2_we", 32'(ram_we), 0);
        tick();
        chk("rel_ack", 32'(hs_ack), 1);
        chk("rel_rdata", 32'(hs_rdata), 32'hC3);
        chk("rel_own_grant", 32'(hs_grant), 1);
        chk("rel_own_we", 32'(ram_we), 0);
        tick();
        chk("rel_grant_fall", 32'(hs_grant), 0);
        chk("rel_pause_hold", 32'(pause_req), 1);
        chk("rel_we_block", 32'(ram_we), 0);
        chk("rel_ack_pulse", 32'(hs_ack), 0);
        tick();
        chk("rel_pause_fall", 32'(pause_req), 0);
        chk("idle_we_pass", 32'(ram_we), 1);
        chk("idle_addr_pass", 32'(ram_addr), 32'h111);
        cpu_we   = 1'b0;
        ack_auto = 1'b0;
        repeat (4) tick();

        // Settle glitch: ack drops in 2nd SETTLE cycle
        hs_req = 1'b1;
        tick();
        ack_man = 1'b1;
        tick();
        tick();
        ack_man = 1'b0;
        tick();
        chk("glitch_grant", 32'(hs_grant), 0);
        chk("glitch_pause", 32'(pause_req), 1);
        ack_man = 1'b1;
        tick();
        repeat (3) tick();
        chk("glitch_settle", 32'(hs_grant), 0);
        tick();
        chk("glitch_own", 32'(hs_grant), 1);
        hs_req = 1'b0;
        tick();
        ack_man = 1'b0;
        tick();
        chk("glitch_idle", 32'(pause_req), 0);

        // Timeout: pause_ack never rises
        hs_req = 1'b1;
        tick();
        repeat (1022) tick();
        chk("to_early", 32'(timeout), 0);
        chk("to_early_pause", 32'(pause_req), 1);
        tick();
        chk("to_fire", 32'(timeout), 1);
        chk("to_pause", 32'(pause_req), 0);
        chk("to_grant", 32'(hs_grant), 0);
        hs_req = 1'b0;
        tick();
        chk("to_clear", 32'(timeout), 0);
        chk("to_clear_pause", 32'(pause_req), 0);

        // Async reset during a write transfer
        ack_man = 1'b1;
        hs_req  = 1'b1;
        repeat (6) tick();
        chk("ar_grant", 32'(hs_grant), 1);
        cpu_addr = 11'h222;
        hs_stb   = 1'b1;
        hs_we    = 1'b1;
        hs_addr  = 11'h055;
        hs_wdata = 8'h99;
        tick();
        hs_stb = 1'b0;
        chk("ar_xfer_we", 32'(ram_we), 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("ar_grant0", 32'(hs_grant), 0);
        chk("ar_pause0", 32'(pause_req), 0);
        chk("ar_we_cpu", 32'(ram_we), 0);
        chk("ar_addr_cpu", 32'(ram_addr), 32'h222);
        chk("ar_ack0", 32'(hs_ack), 0);
        chk("ar_rdata0", 32'(hs_rdata), 0);
        tick();
        chk("ar_no_ack", 32'(hs_ack), 0);
        hs_req  = 1'b0;
        reset_n = 1'b1;
        tick();
        chk("ar_idle", 32'(pause_req), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
